// File: rtl/padded_stream_gen.sv
// Streams a feature map out of buffer memory with a 1-pixel zero border, as 64-bit beats
// ordered row, column, channel group, through a 2-entry skid FIFO.
module padded_stream_gen #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       in_channels,
  input  logic [15:0]       img_width,
  input  logic [15:0]       img_height,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [63:0]       mem_rd_data,
  input  logic              out_ready,
  output logic [63:0]       pixel_out,
  output logic              data_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] FifoDepth = FIFO_DEPTH[1:0];

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [12:0] grp_q, grp_d;
  logic [15:0] wid_q, wid_d;
  logic [15:0] hgt_q, hgt_d;
  logic [16:0] row_q, row_d;
  logic [16:0] col_q, col_d;
  logic [12:0] g_q, g_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic stage_vld_q, stage_vld_d;
  logic stage_pad_q, stage_pad_d;

  logic [63:0] fifo_q [2];
  logic [63:0] fifo_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  cnt_q, cnt_d;

  logic [1:0]  occ;
  logic        pop;
  logic        push;
  logic        issue;
  logic        interior;
  logic        last_pos;
  logic        zero_size;
  logic [16:0] last_row;
  logic [16:0] last_col;
  logic [12:0] last_g;
  logic        unused_ch;

  assign unused_ch = ^in_channels[2:0];

  assign data_valid  = (cnt_q != 2'd0);
  assign pixel_out   = fifo_q[rd_ptr_q];
  assign mem_rd_addr = rd_addr_q;
  assign busy        = (state_q == StRun) || (state_q == StDrain);
  assign done        = (state_q == StDone);

  always_comb begin
    pop       = data_valid && out_ready;
    push      = stage_vld_q;
    // Outstanding work is FIFO entries plus the beat sitting in the issue stage.
    occ       = cnt_q + {1'b0, stage_vld_q};
    issue     = (state_q == StRun) && ((occ < FifoDepth) || pop);
    last_row  = {1'b0, hgt_q} + 17'd1;
    last_col  = {1'b0, wid_q} + 17'd1;
    last_g    = grp_q - 13'd1;
    interior  = (row_q != 17'd0) && (row_q <= {1'b0, hgt_q}) &&
                (col_q != 17'd0) && (col_q <= {1'b0, wid_q});
    last_pos  = (row_q == last_row) && (col_q == last_col) && (g_q == last_g);
    mem_rd_en = issue && interior;
    zero_size = (in_channels[15:3] == 13'd0) || (img_width == 16'd0) || (img_height == 16'd0);
  end

  // Frame configuration, position counters and FSM.
  always_comb begin
    state_d     = state_q;
    grp_d       = grp_q;
    wid_d       = wid_q;
    hgt_d       = hgt_q;
    row_d       = row_q;
    col_d       = col_q;
    g_d         = g_q;
    rd_addr_d   = rd_addr_q;
    stage_vld_d = issue;
    stage_pad_d = issue && !interior;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          grp_d     = in_channels[15:3];
          wid_d     = img_width;
          hgt_d     = img_height;
          row_d     = '0;
          col_d     = '0;
          g_d       = '0;
          rd_addr_d = '0;
          state_d   = zero_size ? StDone : StRun;
        end
      end
      StRun: begin
        if (issue && last_pos) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if ((cnt_d == 2'd0) && !stage_vld_d) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (issue) begin
      if (g_q == last_g) begin
        g_d = '0;
        if (col_q == last_col) begin
          col_d = '0;
          row_d = row_q + 17'd1;
        end else begin
          col_d = col_q + 17'd1;
        end
      end else begin
        g_d = g_q + 13'd1;
      end
    end

    // Interior beats are visited in ascending address order, so a running count suffices.
    if (mem_rd_en) begin
      rd_addr_d = rd_addr_q + ADDR_W'(1);
    end
  end

  // Skid FIFO.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = stage_pad_q ? 64'h0 : mem_rd_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grp_q       <= '0;
      wid_q       <= '0;
      hgt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      g_q         <= '0;
      rd_addr_q   <= '0;
      stage_vld_q <= 1'b0;
      stage_pad_q <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      wid_q       <= wid_d;
      hgt_q       <= hgt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      g_q         <= g_d;
      rd_addr_q   <= rd_addr_d;
      stage_vld_q <= stage_vld_d;
      stage_pad_q <= stage_pad_d;
      fifo_q[0]   <= fifo_d[0];
      fifo_q[1]   <= fifo_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_padded_stream_gen.sv
// Scoreboard bench for padded_stream_gen: expected beats are queued at frame start and a
// negedge monitor pops and compares every accepted beat.
module tb_padded_stream_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in_channels;
  logic [15:0] img_width;
  logic [15:0] img_height;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic        out_ready;
  logic [63:0] pixel_out;
  logic        data_valid;
  logic        busy;
  logic        done;

  padded_stream_gen #(
    .ADDR_W    (32),
    .FIFO_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_channels(in_channels),
    .img_width  (img_width),
    .img_height (img_height),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .out_ready  (out_ready),
    .pixel_out  (pixel_out),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_q[$];
  int beats_seen, n_reads, first_vld_cyc, done_cnt, done_cyc, done_base, t0;
  logic [31:0] exp_addr;
  logic        stall_pend;
  logic [63:0] stall_data;
  int          ready_mode = 0;
  int          tog_end = 0;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {32'hC0DE_0000 + a, ~a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory: request captured mid-cycle, data returned on the following edge.
  logic        req_en;
  logic [31:0] req_addr;
  always @(negedge clk) begin
    req_en   <= mem_rd_en;
    req_addr <= mem_rd_addr;
  end
  always @(posedge clk) mem_rd_data <= req_en ? mem_word(req_addr) : 64'hBAD0_BAD0_BAD0_BAD0;

  // Monitor.
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_valid", 64'(data_valid), 64'd1);
        check("stall_data", pixel_out, stall_data);
      end
      if (data_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_beat: got %h, expected no beat", pixel_out);
        end else begin
          check($sformatf("beat%0d", beats_seen), pixel_out, exp_q.pop_front());
        end
        if (beats_seen == 0) first_vld_cyc = cyc;
        beats_seen++;
      end
      stall_pend = data_valid && !out_ready;
      stall_data = pixel_out;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mem_rd_en) begin
        check("rd_addr", 64'(mem_rd_addr), 64'(exp_addr));
        exp_addr++;
        n_reads++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else if (cyc < tog_end) out_ready = (cyc % 2 == 0);
    else out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input int ch, input int w, input int h, output int nb, output int nr);
    int g_n;
    g_n = ch >> 3;
    nb  = 0;
    nr  = 0;
    for (int r = 0; r <= h + 1; r++)
      for (int c = 0; c <= w + 1; c++)
        for (int g = 0; g < g_n; g++) begin
          if (r >= 1 && r <= h && c >= 1 && c <= w) begin
            exp_q.push_back(mem_word(32'(((r - 1) * w + (c - 1)) * g_n + g)));
            nr++;
          end else begin
            exp_q.push_back(64'h0);
          end
          nb++;
        end
  endtask

  task automatic frame_start(input int ch, input int w, input int h);
    beats_seen    = 0;
    n_reads       = 0;
    exp_addr      = 0;
    first_vld_cyc = -1;
    done_base     = done_cnt;
    @(negedge clk);
    in_channels = 16'(ch);
    img_width   = 16'(w);
    img_height  = 16'(h);
    start       = 1'b1;
    @(posedge clk);
    #1;
    t0          = cyc;
    start       = 1'b0;
    // Scrambled inputs must not affect the running frame.
    in_channels = 16'hFFFF;
    img_width   = 16'd7;
    img_height  = 16'd9;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == done_base && k < budget) begin
      tick();
      k++;
    end
    if (done_cnt == done_base) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done", budget);
    end
  endtask

  task automatic frame_end(input string name, input int nb, input int nr);
    repeat (4) tick();
    check({name, "_beats"}, 64'(beats_seen), 64'(nb));
    check({name, "_reads"}, 64'(n_reads), 64'(nr));
    check({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done_cnt"}, 64'(done_cnt - done_base), 64'd1);
  endtask

  task automatic check_idle(input string name);
    check({name, "_valid"}, 64'(data_valid), 64'd0);
    check({name, "_pixel"}, pixel_out, 64'd0);
    check({name, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    check({name, "_rd_addr"}, 64'(mem_rd_addr), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nr;
    logic [63:0] e;
    rst = 1'b1; start = 1'b0; in_channels = 0; img_width = 0; img_height = 0; out_ready = 1'b1;
    beats_seen = 0; n_reads = 0; done_cnt = 0; done_cyc = 0; done_base = 0; exp_addr = 0;
    stall_pend = 1'b0; stall_data = '0; first_vld_cyc = -1; t0 = 0;
    repeat (3) tick();
    rst = 1'b0;
    check_idle("reset");

    // W=2 H=2 C=8: hand-computed beat map, interior beats 5,6,9,10.
    for (int i = 0; i < 16; i++) begin
      e = 64'h0;
      if (i == 5) e = mem_word(0);
      if (i == 6) e = mem_word(1);
      if (i == 9) e = mem_word(2);
      if (i == 10) e = mem_word(3);
      exp_q.push_back(e);
    end
    frame_start(8, 2, 2);
    check("f1_busy_run", 64'(busy), 64'd1);
    wait_done(200);
    check("f1_first_valid", 64'(first_vld_cyc - t0), 64'd2);
    check("f1_done_cyc", 64'(done_cyc - t0), 64'd18);
    frame_end("f1", 16, 4);

    // W=1 H=1 C=16.
    push_model(16, 1, 1, nb, nr);
    frame_start(16, 1, 1);
    wait_done(200);
    frame_end("f2", nb, nr);
    check("f2_nb", 64'(nb), 64'd18);

    // W=3 H=2 C=8 with toggling then random stalls.
    ready_mode = 1;
    tog_end    = cyc + 12;
    push_model(8, 3, 2, nb, nr);
    frame_start(8, 3, 2);
    wait_done(500);
    ready_mode = 0;
    frame_end("f3", nb, nr);

    // G=0 frame.
    frame_start(4, 3, 3);
    wait_done(20);
    check("g0_done_window", 64'((done_cyc >= t0) && (done_cyc <= t0 + 1)), 64'd1);
    frame_end("g0", 0, 0);

    // Reset mid-frame at beat 7.
    push_model(8, 2, 2, nb, nr);
    frame_start(8, 2, 2);
    begin
      int k = 0;
      while (beats_seen < 7 && k < 100) begin
        tick();
        k++;
      end
    end
    check("rst_reached_beat7", 64'(beats_seen), 64'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check_idle("midrst");
    repeat (20) tick();
    check("midrst_no_done", 64'(done_cnt - done_base), 64'd0);
    check("midrst_no_valid", 64'(data_valid), 64'd0);

    push_model(8, 2, 2, nb, nr);
    frame_start(8, 2, 2);
    wait_done(200);
    frame_end("after_rst", nb, nr);

    // start pulses while busy are ignored.
    push_model(16, 2, 1, nb, nr);
    frame_start(16, 2, 1);
    repeat (3) tick();
    @(negedge clk);
    start = 1'b1; in_channels = 16'd8; img_width = 16'd1; img_height = 16'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(300);
    frame_end("restart_ignored", nb, nr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/padded_stream_gen.md
Name: padded_stream_gen

Overview:
- Producer end of the kernel-window pixel stream.
- Reads an unpadded feature map from on-chip buffer memory in 64-bit words (8 channels per word).
- Inserts a 1-pixel zero border on all four sides.
- Emits the padded frame as a 64-bit beat stream in the order the 3x3 window generator consumes: row-major, then column, then channel group. Its output drives that block's pixel_in/data_valid; padded width W+2 goes to that block's img_width.

Parameters:
- ADDR_W, 32, width of mem_rd_addr.
- FIFO_DEPTH, 2, output skid FIFO entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle frame start pulse; sampled only in IDLE
- in_channels  in  16  channel count; G = in_channels>>3 groups per pixel
- img_width  in  16  unpadded width W
- img_height  in  16  unpadded height H
- mem_rd_en  out  1  read strobe
- mem_rd_addr  out  ADDR_W  word address
- mem_rd_data  in  64  read data, valid exactly 1 cycle after mem_rd_en
- out_ready  in  1  downstream accept
- pixel_out  out  64  beat data
- data_valid  out  1  beat valid
- busy  out  1  high from RUN entry until done
- done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset values: data_valid=0, pixel_out=0, mem_rd_en=0, mem_rd_addr=0, busy=0, done=0. FSM returns to IDLE. Counters and FIFO are cleared and in-flight reads discarded. Reset mid-frame aborts with no done pulse.
- On start in IDLE, latch in_channels, img_width and img_height. Later input changes are ignored until the next frame.
- If G==0, W==0 or H==0: go to DONE and pulse done the next cycle. No beats, no reads.
- FSM states: IDLE -> RUN (start) -> DRAIN (last beat issued) -> DONE (FIFO empty and no in-flight) -> IDLE (after 1 cycle, done=1 during DONE).
- busy=1 in RUN and DRAIN. start is ignored outside IDLE.
- Counters: r in 0..H+1, c in 0..W+1, g in 0..G-1.
  - Advance order: g, then c on g wrap, then r on c wrap.
  - Total beats = (H+2)*(W+2)*G, computed in 32 bits; inputs are limited so the product fits.
- Beat issue in RUN: each issued beat is tagged pad or interior.
  - Interior (1<=r<=H and 1<=c<=W): mem_rd_en=1 with mem_rd_addr = ((r-1)*W + (c-1))*G + g.
  - Pad: no read, mem_rd_en=0.
- Issue pipeline: a 1-cycle stage carries the pad flag.
  - Next cycle, the FIFO is written with 64'h0 if pad, else mem_rd_data.
  - Pad and interior beats therefore share latency and stay in order.
- Flow control:
  - Issue only if (fifo_count + inflight) < 2, or if a FIFO pop occurs in the same cycle.
  - This guarantees no FIFO overflow and never drops read data.
  - No issue in IDLE, DRAIN or DONE.
- Output handshake:
  - data_valid = FIFO non-empty; pixel_out = FIFO head.
  - Pop when data_valid && out_ready.
  - pixel_out and data_valid stay stable while data_valid && !out_ready.
- Simultaneous push and pop on the same cycle are both honoured.
- Latency: start sampled at cycle T; first issue at T+1; first data_valid at T+2.
- Throughput: with out_ready held high, one beat per cycle, no bubbles, including across pad/interior boundaries.
- done timing: done asserts the cycle after the final pop, for exactly one cycle; busy drops in the same cycle.

Test Plan:
- W=2,H=2,in_channels=8, out_ready=1 -> 16 beats on consecutive cycles T+2..T+17.
  - Beats 5,6,9,10 carry memory words at addr 0,1,2,3.
  - All other beats are 0; exactly 4 mem_rd_en pulses.
  - done at T+18.
- W=1,H=1,in_channels=16 -> 18 beats; beats 8,9 read addr 0,1; all other beats zero.
- W=3,H=2,in_channels=8, out_ready toggling 1010... and random stalls -> all 20 beats delivered in order, none duplicated. pixel_out stays stable during stalls.
- in_channels=4 (G=0) -> no data_valid, no mem_rd_en; done pulse one cycle after DONE entry; busy returns 0.
- Assert rst for 1 cycle mid-frame (beat 7 of 16) -> next cycle all outputs 0, state IDLE, no done. A subsequent start produces a full correct frame.
- start pulsed again while busy -> ignored; frame completes normally with a single done pulse.
